// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// pipeline_hazard_ctrl: merges load-use, branch redirect and memory-wait into
// per-stage we/flush/bubble controls; keeps stall/flush statistics. Rev 1.0
module pipeline_hazard_ctrl #(
  parameter int MEM_WAIT_MAX = 15,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_use_pause,
  input  logic             branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_we,
  output logic             if_id_we,
  output logic             id_ex_we,
  output logic             ex_mem_we,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_bubble,
  output logic             mem_wb_bubble,
  output logic [1:0]       ctrl_state,
  output logic             timeout_err,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    MEM_WAIT = 2'd2,
    ERR      = 2'd3
  } state_t;

  localparam logic [7:0]       WAIT_MAX = 8'(MEM_WAIT_MAX);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  state_t     state;
  logic [7:0] wait_cnt;
  logic       mem_stall;
  logic       freeze;
  logic       lu_act;
  logic       br_act;

  assign mem_stall  = mem_req & ~mem_ready;
  assign ctrl_state = state;

  // Pick the single winning action for this cycle; outputs follow from it.
  always_comb begin
    freeze = 1'b0;
    lu_act = 1'b0;
    br_act = 1'b0;
    if (!rst) begin
      case (state)
        ERR:      freeze = 1'b1;
        MEM_WAIT: freeze = mem_stall;
        default: begin
          if (mem_stall)           freeze = 1'b1;
          else if (load_use_pause) lu_act = 1'b1;
          else if (branch_taken)   br_act = 1'b1;
        end
      endcase
    end
  end

  always_comb begin
    pc_we         = 1'b1;
    if_id_we      = 1'b1;
    id_ex_we      = 1'b1;
    ex_mem_we     = 1'b1;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_bubble = 1'b0;
    mem_wb_bubble = 1'b0;
    if (rst) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
      ex_mem_bubble = 1'b1;
      mem_wb_bubble = 1'b1;
    end else if (freeze) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_we     = 1'b0;
      mem_wb_bubble = 1'b1;
    end else if (lu_act) begin
      pc_we         = 1'b0;
      if_id_we      = 1'b0;
      id_ex_we      = 1'b0;
      ex_mem_bubble = 1'b1;
    end else if (br_act) begin
      if_id_flush   = 1'b1;
      id_ex_flush   = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      wait_cnt     <= 8'd0;
      stall_cycles <= '0;
      flush_events <= '0;
      timeout_err  <= 1'b0;
    end else begin
      if (!pc_we && stall_cycles != CNT_MAX) stall_cycles <= stall_cycles + 1'b1;
      if (br_act && flush_events != CNT_MAX) flush_events <= flush_events + 1'b1;
      case (state)
        MEM_WAIT: begin
          if (!mem_stall) begin
            state    <= RUN;
            wait_cnt <= 8'd0;
          end else if (wait_cnt >= WAIT_MAX) begin
            state       <= ERR;
            timeout_err <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        ERR: state <= ERR;
        default: begin
          if (freeze) begin
            state    <= MEM_WAIT;
            wait_cnt <= 8'd1;
          end else if (lu_act) begin
            state <= LU_STALL;
          end else begin
            state <= RUN;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
